// File: rtl/tt_capture4_if.sv
// tt_capture4_if: capture request, stimulus/response and result handshake
// between the truth-table capture engine (slave) and its user (master).
// Optional feature macro: TT_COMPARE_EN adds exp_tt and match.
interface tt_capture4_if;
  logic        start;
  logic [3:0]  x_o;
  logic        y_i;
  logic        busy;
  logic [15:0] tt;
  logic        tt_valid;
  logic        tt_ready;
`ifdef TT_COMPARE_EN
  logic [15:0] exp_tt;
  logic        match;

  modport master (
    output start, y_i, tt_ready, exp_tt,
    input  x_o, busy, tt, tt_valid, match
  );

  modport slave (
    input  start, y_i, tt_ready, exp_tt,
    output x_o, busy, tt, tt_valid, match
  );
`else
  modport master (
    output start, y_i, tt_ready,
    input  x_o, busy, tt, tt_valid
  );

  modport slave (
    input  start, y_i, tt_ready,
    output x_o, busy, tt, tt_valid
  );
`endif
endinterface

// File: rtl/tt_capture4.sv
// tt_capture4: walks x_o through all 16 minterms of an external 4-input
// function, waits SETTLE extra cycles per minterm, samples y_i into tt[idx]
// and presents the complete table with a valid/ready handshake.
// Optional feature macro: TT_COMPARE_EN (exp_tt input, match output).
module tt_capture4 #(
  parameter int unsigned SETTLE = 0  // 0..15
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_capture4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [3:0]  wait_cnt;
  logic [15:0] tt_q;
  logic        accept;
  logic        sample;

  assign accept = (state == IDLE) && bus.start;
  assign sample = (state == RUN) && (wait_cnt == SETTLE_W);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: last sample (idx 15) finishes the run
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (sample && (idx == 4'hF)) state_nxt = DONE;
      DONE:    if (bus.tt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Minterm index, settle counter and table capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      wait_cnt <= '0;
      tt_q     <= '0;
    end else if (accept) begin
      idx      <= '0;
      wait_cnt <= '0;
    end else if (state == RUN) begin
      if (sample) begin
        tt_q[idx] <= bus.y_i;
        wait_cnt  <= '0;
        idx       <= idx + 4'd1;  // wraps to 0 after the 16th sample
      end else begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  assign bus.x_o      = (state == RUN) ? idx : '0;
  assign bus.busy     = (state == RUN);
  assign bus.tt_valid = (state == DONE);
  assign bus.tt       = tt_q;

`ifdef TT_COMPARE_EN
  logic [15:0] exp_q;

  // Expected table latched when a capture is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      exp_q <= '0;
    else if (accept) exp_q <= bus.exp_tt;
  end

  assign bus.match = (state == DONE) && (tt_q == exp_q);
`endif

endmodule

// File: tb/tb_tt_capture4.sv
// tb_tt_capture4: two capture engines (SETTLE=0 and SETTLE=2) checked every
// cycle against a cycle-count model, plus literal table/latency checks.
`timescale 1ns/1ps
module tb_tt_capture4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_capture4_if bus0 ();
  tt_capture4_if bus1 ();

  logic        start_v [2];
  logic        ready_v [2];
  int          fsel    [2];
  logic [15:0] tbl = 16'hA5C3;
  int          checks   = 0;
  int          failures = 0;

  // External functions: 0 = x0&x1, 1 = parity, 2 = x3, 3 = table lookup
  function automatic logic fn(input int sel, input logic [3:0] x);
    case (sel)
      0:       return x[0] & x[1];
      1:       return ^x;
      2:       return x[3];
      default: return tbl[x];
    endcase
  endfunction

  assign bus0.start    = start_v[0];
  assign bus0.tt_ready = ready_v[0];
  assign bus0.y_i      = fn(fsel[0], bus0.x_o);
  assign bus1.start    = start_v[1];
  assign bus1.tt_ready = ready_v[1];
  assign bus1.y_i      = fn(fsel[1], bus1.x_o);

`ifdef TT_COMPARE_EN
  logic [15:0] exp_v [2];
  logic [15:0] m_exp [2];
  assign bus0.exp_tt = exp_v[0];
  assign bus1.exp_tt = exp_v[1];
`endif

  tt_capture4 #(.SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tt_capture4 #(.SETTLE(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: 0 idle, 1 capturing, 2 holding result; cyc = edges since acceptance
  int          m_st  [2];
  int          m_cyc [2];
  logic [15:0] m_tt  [2];

  function automatic int per_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [3:0] minterm_of(input int d, input int cyc);
    return 4'(cyc / per_of(d));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_st[d]  <= 0;
        m_cyc[d] <= 0;
        m_tt[d]  <= '0;
      end else begin
        case (m_st[d])
          0: if (start_v[d]) begin
               m_st[d]  <= 1;
               m_cyc[d] <= 0;
`ifdef TT_COMPARE_EN
               m_exp[d] <= exp_v[d];
`endif
             end
          1: begin
               if ((m_cyc[d] + 1) % per_of(d) == 0)
                 m_tt[d][minterm_of(d, m_cyc[d])] <= fn(fsel[d], minterm_of(d, m_cyc[d]));
               m_cyc[d] <= m_cyc[d] + 1;
               if (m_cyc[d] + 1 == 16 * per_of(d)) m_st[d] <= 2;
             end
          default: if (ready_v[d]) m_st[d] <= 0;
        endcase
      end
    end
  end

  task automatic cmp_dut(input int d, input logic busy, input logic valid,
                         input logic [3:0] x, input logic [15:0] tt);
    chk($sformatf("d%0d_busy", d),  32'(busy),  32'(m_st[d] == 1));
    chk($sformatf("d%0d_valid", d), 32'(valid), 32'(m_st[d] == 2));
    chk($sformatf("d%0d_x", d),     32'(x),
        32'((m_st[d] == 1) ? minterm_of(d, m_cyc[d]) : 4'd0));
    chk($sformatf("d%0d_tt", d),    32'(tt),    32'(m_tt[d]));
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    cmp_dut(0, bus0.busy, bus0.tt_valid, bus0.x_o, bus0.tt);
    cmp_dut(1, bus1.busy, bus1.tt_valid, bus1.x_o, bus1.tt);
`ifdef TT_COMPARE_EN
    chk("d0_match", 32'(bus0.match), 32'((m_st[0] == 2) && (m_tt[0] == m_exp[0])));
    chk("d1_match", 32'(bus1.match), 32'((m_st[1] == 2) && (m_tt[1] == m_exp[1])));
`endif
  end

  function automatic logic valid_of(input int d);
    return (d == 0) ? bus0.tt_valid : bus1.tt_valid;
  endfunction

  // Pulse start, count edges until tt_valid; optional extra start pulse mid-run
  task automatic run_capture(input int d, input int pulse_at, output int edges);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    edges = 0;
    while (!valid_of(d) && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      start_v[d] = (edges == pulse_at);
    end
    start_v[d] = 1'b0;
  endtask

  task automatic release_tt(input int d);
    ready_v[d] = 1'b1;
    @(posedge clk); #1;
    ready_v[d] = 1'b0;
    chk($sformatf("d%0d_rel_valid", d), 32'(valid_of(d)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int n;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    ready_v[0] = 1'b0; ready_v[1] = 1'b0;
    fsel[0] = 0; fsel[1] = 1;
`ifdef TT_COMPARE_EN
    exp_v[0] = '0; exp_v[1] = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0",  32'(bus0.busy),     32'd0);
    chk("rst_valid0", 32'(bus0.tt_valid), 32'd0);
    chk("rst_x0",     32'(bus0.x_o),      32'd0);
    chk("rst_tt0",    32'(bus0.tt),       32'd0);
    rst_n = 1'b1;

    // x0&x1, SETTLE=0
    run_capture(0, -1, e);
    chk("lat_settle0", 32'(e), 32'd16);
    chk("tt_and",      32'(bus0.tt), 32'h8888);
    release_tt(0);

    // parity, SETTLE=2, start pulse mid-run ignored
    run_capture(1, 10, e);
    chk("lat_settle2", 32'(e), 32'd48);
    chk("tt_parity",   32'(bus1.tt), 32'h6996);

    // hold in DONE with tt_ready low, start pulse ignored
    for (int i = 0; i < 10; i++) begin
      start_v[1] = (i == 4);
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus1.tt_valid), 32'd1);
      chk("hold_tt",    32'(bus1.tt),       32'h6996);
    end
    // start coincident with the release edge is dropped
    ready_v[1] = 1'b1; start_v[1] = 1'b1;
    @(posedge clk); #1;
    ready_v[1] = 1'b0; start_v[1] = 1'b0;
    chk("rel_busy",  32'(bus1.busy),     32'd0);
    chk("rel_valid", 32'(bus1.tt_valid), 32'd0);
    @(posedge clk); #1;
    chk("no_queue_busy", 32'(bus1.busy), 32'd0);

    // table persists in IDLE
    chk("idle_keep_tt", 32'(bus0.tt), 32'h8888);

    // asynchronous reset at minterm 7
    fsel[0] = 3;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (bus0.x_o != 4'd7 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idx7", 32'(bus0.x_o), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy0",  32'(bus0.busy),     32'd0);
    chk("arst_x0",     32'(bus0.x_o),      32'd0);
    chk("arst_tt0",    32'(bus0.tt),       32'd0);
    chk("arst_valid0", 32'(bus0.tt_valid), 32'd0);
    chk("arst_tt1",    32'(bus1.tt),       32'd0);
    #1 rst_n = 1'b1;

    // first start after reset release, full capture
    run_capture(0, -1, e);
    chk("lat_after_rst", 32'(e), 32'd16);
    chk("tt_table",      32'(bus0.tt), 32'hA5C3);
    release_tt(0);

    // x3 on SETTLE=2 engine
    fsel[1] = 2;
`ifdef TT_COMPARE_EN
    exp_v[1] = 16'hFF00;
`endif
    run_capture(1, -1, e);
    chk("tt_x3", 32'(bus1.tt), 32'hFF00);
`ifdef TT_COMPARE_EN
    chk("match_hit", 32'(bus1.match), 32'd1);
`endif
    release_tt(1);
`ifdef TT_COMPARE_EN
    exp_v[1] = 16'hFF01;
    run_capture(1, -1, e);
    chk("match_miss", 32'(bus1.match), 32'd0);
    release_tt(1);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_capture4.md
TT_CAPTURE4 -- requirements
Module: tt_capture4

Interface
REQ-001 Parameter SETTLE, default 0: extra wait cycles per minterm before sampling y_i, legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a capture; accepted only in IDLE.
REQ-005 x_o  output  4  registered stimulus to the external 4-input function; x_o[0] drives x0 … x_o[3] drives x3.
REQ-006 y_i  input  1  function response y0, combinational from x_o.
REQ-007 busy  output  1  high while in RUN.
REQ-008 tt  output  16  captured truth table; tt[m] = y0 for x3..x0 = m.
REQ-009 tt_valid  output  1  tt holds a complete capture.
REQ-010 tt_ready  input  1  consumer accepts tt when high together with tt_valid.

Function
REQ-011 States: IDLE, RUN, DONE; encoding is free.
REQ-012 IDLE: x_o=0, busy=0, tt_valid=0; start=1 at an edge loads idx=0, wait=0 and enters RUN.
REQ-013 RUN: x_o=idx; busy=1 combinationally from state.
REQ-014 RUN, per edge: wait<SETTLE -> wait+1; wait==SETTLE -> tt[idx]<=y_i, wait<=0, idx<=idx+1.
REQ-015 RUN: sampling at idx==15 enters DONE; idx is 4 bits and wraps to 0, with no 17th sample.
REQ-016 Latency: start accepted at edge E0 -> tt_valid high after edge E0+16*(SETTLE+1); with SETTLE=0, 16 edges.
REQ-017 y_i is sampled only after x_o has been stable for SETTLE+1 full cycles.
REQ-018 DONE: tt_valid=1, x_o=0, tt stable; tt_ready=1 at an edge -> IDLE, tt_valid=0 next cycle.
REQ-019 DONE with tt_ready=0: hold tt and tt_valid indefinitely.
REQ-020 start during RUN or DONE is ignored and not queued.
REQ-021 start=1 in the same cycle DONE->IDLE fires is ignored; start must be high in IDLE.
REQ-022 tt keeps its last value in IDLE; it is overwritten bitwise during the next RUN.

Reset
REQ-023 rst_n=0 immediately forces IDLE, idx=0, wait=0, tt=0, tt_valid=0, busy=0, x_o=0 (match=0 when compiled in).
REQ-024 Reset mid-RUN or mid-DONE aborts the capture with no partial result.
REQ-025 First start is accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro TT_COMPARE_EN defined: adds input exp_tt[15:0], registered at start acceptance, and output match (1 bit).
REQ-027 With TT_COMPARE_EN: match = (tt==exp_tt), valid while tt_valid=1 and 0 otherwise.
REQ-028 Without TT_COMPARE_EN: exp_tt and match ports are absent; all other behaviour is identical.

Verification
REQ-029 SETTLE=0, y_i=x0&x1, start pulse -> x_o steps 0..15, one value per cycle; tt_valid after 16 edges; tt=0x8888.
REQ-030 SETTLE=2, y_i=x0^x1^x2^x3 -> each x_o value held 3 cycles; tt_valid after 48 edges; tt=0x6996.
REQ-031 DONE with tt_ready=0 for 10 cycles, then 1 for 1 cycle -> tt and tt_valid held; IDLE next cycle; start pulses during RUN/DONE ignored.
REQ-032 rst_n low at idx=7 -> all outputs 0 asynchronously; a new start yields a full correct capture.
REQ-033 TT_COMPARE_EN, y_i=x3, exp_tt=0xFF00 -> match=1; exp_tt=0xFF01 -> match=0.
